// File: rtl/dram_bank_timing.sv
// Multi-bank DRAM command-timing tracker: per-bank tRCD/tRAS/tRP, rank tRFC, tCL read strobe.
// Define DRAM_BANK_TIMING_AP_EN to accept RD/WR with auto-precharge (cmd_ap=1).
module dram_bank_timing #(
  parameter int BANKS = 4,
  parameter int BA_W  = 2,
  parameter int CTR_W = 9,
  parameter int T_RCD = 17,
  parameter int T_CL  = 17,
  parameter int T_RAS = 39,
  parameter int T_RP  = 17,
  parameter int T_RFC = 347
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic             cmd_ap,
  input  logic [BA_W-1:0]  cmd_ba,
  output logic             cmd_legal,
  output logic             cmd_err,
  output logic [BANKS-1:0] bank_open,
  output logic [BANKS-1:0] bank_busy,
  output logic             ref_busy,
  output logic             rd_valid,
  output logic [BA_W-1:0]  rd_ba
);
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACTG = 2'd1, S_ACTV = 2'd2, S_PRE = 2'd3;
  localparam logic [CTR_W-1:0] CT_ZERO = '0;
  localparam logic [CTR_W-1:0] CT_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] RCD_LD  = CTR_W'(T_RCD - 1);
  localparam logic [CTR_W-1:0] RAS_LD  = CTR_W'(T_RAS - 1);
  localparam logic [CTR_W-1:0] RP_LD   = CTR_W'(T_RP - 1);
  localparam logic [CTR_W-1:0] RFC_LD  = CTR_W'(T_RFC - 1);

  logic [BANKS-1:0][1:0]       st_q, st_d;
  logic [BANKS-1:0][CTR_W-1:0] rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d;
  logic [CTR_W-1:0]            rfc_q, rfc_d;
  logic                        ref_q, ref_d;
  logic                        err_q, err_d;
  logic [T_CL-1:0]             pv_q, pv_d;
  logic [T_CL-1:0][BA_W-1:0]   pba_q, pba_d;
  logic [BANKS-1:0]            hit_s, ap_fire_s;
  logic                        legal_s, ok_s, acc_s, all_idle_s, prea_ok_s, rdwr_ok_s;

`ifdef DRAM_BANK_TIMING_AP_EN
  localparam logic AP_OK = 1'b1;
  logic [BANKS-1:0] ap_pend_q, ap_pend_d;
`else
  localparam logic AP_OK = 1'b0;
  logic [BANKS-1:0] ap_pend_q;
  assign ap_pend_q = '0;
`endif

  function automatic logic [CTR_W-1:0] dec(input logic [CTR_W-1:0] v);
    return (v == CT_ZERO) ? CT_ZERO : v - CT_ONE;
  endfunction

  always_comb begin
    all_idle_s = 1'b1;
    prea_ok_s  = 1'b1;
    for (int b = 0; b < BANKS; b++) begin
      if (st_q[b] != S_IDLE) all_idle_s = 1'b0;
      if (st_q[b] == S_ACTG || (st_q[b] == S_ACTV && ras_q[b] != CT_ZERO)) prea_ok_s = 1'b0;
    end
    // RD/WR may issue on the edge that closes the tRCD window
    rdwr_ok_s = (st_q[cmd_ba] == S_ACTV || (st_q[cmd_ba] == S_ACTG && rcd_q[cmd_ba] == CT_ZERO))
                && !ap_pend_q[cmd_ba] && (AP_OK || !cmd_ap);
    case (cmd)
      C_NOP:      legal_s = 1'b1;
      C_ACT:      legal_s = (st_q[cmd_ba] == S_IDLE);
      C_RD, C_WR: legal_s = rdwr_ok_s;
      C_PRE:      legal_s = (st_q[cmd_ba] == S_IDLE) ||
                            (st_q[cmd_ba] == S_ACTV && ras_q[cmd_ba] == CT_ZERO);
      C_PREA:     legal_s = prea_ok_s;
      C_REF:      legal_s = all_idle_s;
      default:    legal_s = 1'b0;
    endcase
    ok_s  = legal_s && !(ref_q && cmd != C_NOP);
    acc_s = cmd_valid && ok_s;
    err_d = cmd_valid && !ok_s;
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      hit_s[b] = acc_s && (cmd_ba == BA_W'(b));
      st_d[b]  = st_q[b];
      rcd_d[b] = dec(rcd_q[b]);
      ras_d[b] = dec(ras_q[b]);
      rp_d[b]  = dec(rp_q[b]);
`ifdef DRAM_BANK_TIMING_AP_EN
      ap_fire_s[b] = ap_pend_q[b] && (ras_q[b] == CT_ZERO);
`else
      ap_fire_s[b] = 1'b0;
`endif
      case (st_q[b])
        S_IDLE: begin
          if (hit_s[b] && cmd == C_ACT) begin
            st_d[b]  = S_ACTG;
            rcd_d[b] = RCD_LD;
            ras_d[b] = RAS_LD;
          end else begin
            st_d[b] = S_IDLE;
          end
        end
        S_ACTG: st_d[b] = (rcd_q[b] == CT_ZERO) ? S_ACTV : S_ACTG;
        S_ACTV: begin
          if ((hit_s[b] && cmd == C_PRE) || (acc_s && cmd == C_PREA) || ap_fire_s[b]) begin
            st_d[b] = S_PRE;
            rp_d[b] = RP_LD;
          end else begin
            st_d[b] = S_ACTV;
          end
        end
        S_PRE:   st_d[b] = (rp_q[b] == CT_ZERO) ? S_IDLE : S_PRE;
        default: st_d[b] = S_IDLE;
      endcase
`ifdef DRAM_BANK_TIMING_AP_EN
      if (st_d[b] == S_PRE) ap_pend_d[b] = 1'b0;
      else if (hit_s[b] && (cmd == C_RD || cmd == C_WR) && cmd_ap) ap_pend_d[b] = 1'b1;
      else ap_pend_d[b] = ap_pend_q[b];
`endif
    end
  end

  // Rank refresh window and the tCL-deep read-return pipe.
  always_comb begin
    rfc_d = dec(rfc_q);
    if (acc_s && cmd == C_REF) begin
      ref_d = 1'b1;
      rfc_d = RFC_LD;
    end else if (ref_q && rfc_q == CT_ZERO) begin
      ref_d = 1'b0;
    end else begin
      ref_d = ref_q;
    end
    pv_d[0]  = acc_s && (cmd == C_RD);
    pba_d[0] = pv_d[0] ? cmd_ba : '0;
    for (int i = 1; i < T_CL; i++) begin
      pv_d[i]  = pv_q[i-1];
      pba_d[i] = pba_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= '0;
      rcd_q <= '0;
      ras_q <= '0;
      rp_q  <= '0;
      rfc_q <= '0;
      ref_q <= 1'b0;
      err_q <= 1'b0;
      pv_q  <= '0;
      pba_q <= '0;
    end else begin
      st_q  <= st_d;
      rcd_q <= rcd_d;
      ras_q <= ras_d;
      rp_q  <= rp_d;
      rfc_q <= rfc_d;
      ref_q <= ref_d;
      err_q <= err_d;
      pv_q  <= pv_d;
      pba_q <= pba_d;
    end
  end

`ifdef DRAM_BANK_TIMING_AP_EN
  always_ff @(posedge clk) begin
    if (rst) ap_pend_q <= '0;
    else     ap_pend_q <= ap_pend_d;
  end
`endif

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bank_open[b] = (st_q[b] == S_ACTV);
      bank_busy[b] = (st_q[b] == S_ACTG) || (st_q[b] == S_PRE);
    end
  end

  assign cmd_legal = acc_s;
  assign cmd_err   = err_q;
  assign ref_busy  = ref_q;
  assign rd_valid  = pv_q[T_CL-1];
  assign rd_ba     = pba_q[T_CL-1];
endmodule

// File: tb/tb_dram_bank_timing.sv
// Scoreboard bench for dram_bank_timing: driver queues expected cmd_err and rd_valid/rd_ba,
// a negedge monitor pops and compares.
module tb_dram_bank_timing;
  localparam int T_CL = 17;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
  localparam logic [2:0] PRE = 3'd4, PREA = 3'd5, REF = 3'd6, RSV = 3'd7;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ap = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [1:0] cmd_ba = 2'd0;
  logic       cmd_legal, cmd_err, ref_busy, rd_valid;
  logic [3:0] bank_open, bank_busy;
  logic [1:0] rd_ba;

  typedef struct packed { logic [31:0] due; logic v; } err_t;
  typedef struct packed { logic [31:0] due; logic [1:0] ba; } rd_t;
  err_t errq[$];
  rd_t  rdq[$];
  int   cyc = 0, checks = 0, failures = 0, k = 0;

  dram_bank_timing dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ap(cmd_ap), .cmd_ba(cmd_ba),
    .cmd_legal(cmd_legal), .cmd_err(cmd_err), .bank_open(bank_open), .bank_busy(bank_busy),
    .ref_busy(ref_busy), .rd_valid(rd_valid), .rd_ba(rd_ba)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare registered outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (errq.size() > 0 && errq[0].due == cyc) begin
      checks++;
      if (cmd_err !== errq[0].v) begin
        failures++;
        $display("FAIL cmd_err cyc=%0d got=%0b exp=%0b", cyc, cmd_err, errq[0].v);
      end
      void'(errq.pop_front());
    end
    while (rdq.size() > 0 && rdq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL rd_missing cyc=%0d got=none exp_ba=%0d", cyc, rdq[0].ba);
      void'(rdq.pop_front());
    end
    if (rd_valid === 1'b1) begin
      checks++;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        if (rd_ba !== rdq[0].ba) begin
          failures++;
          $display("FAIL rd_ba cyc=%0d got=%0d exp=%0d", cyc, rd_ba, rdq[0].ba);
        end
        void'(rdq.pop_front());
      end else begin
        failures++;
        $display("FAIL rd_stray cyc=%0d got=rd_valid exp=idle", cyc);
      end
    end else if (rdq.size() > 0 && rdq[0].due == cyc) begin
      checks++; failures++;
      $display("FAIL rd_missing cyc=%0d got=%b exp_ba=%0d", cyc, rd_valid, rdq[0].ba);
      void'(rdq.pop_front());
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", nm, k, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic ap,
                       input logic exp, input string nm);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_ba = ba; cmd_ap = ap;
    #1;
    chk(nm, {31'd0, cmd_legal}, {31'd0, exp});
    errq.push_back('{due: cyc + 1, v: ~exp});
    if (exp && c == RD) rdq.push_back('{due: cyc + T_CL, ba: ba});
    k++;
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0; cmd = NOP; cmd_ba = 2'd0; cmd_ap = 1'b0;
    errq.push_back('{due: cyc + 1, v: 1'b0});
    k++;
  endtask

  task automatic idle_to(input int t);
    while (k < t) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; cmd = NOP; cmd_ap = 1'b0;
    for (int i = errq.size() - 1; i >= 0; i--) if (errq[i].due > cyc) errq[i].v = 1'b0;
    for (int i = rdq.size() - 1; i >= 0; i--) if (rdq[i].due > cyc) rdq.delete(i);
    errq.push_back('{due: cyc + 1, v: 1'b0});
    @(negedge clk);
    errq.push_back('{due: cyc + 1, v: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    errq.push_back('{due: cyc + 1, v: 1'b0});
    chk("rst_open", {28'd0, bank_open}, 32'd0);
    chk("rst_busy", {28'd0, bank_busy}, 32'd0);
    chk("rst_ref", {31'd0, ref_busy}, 32'd0);
    chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdba", {30'd0, rd_ba}, 32'd0);
    k = 0;
  endtask

  initial begin
    // tRCD boundary, reserved code, PRE to idle bank
    do_reset();
    issue(ACT, 2'd0, 1'b0, 1'b1, "act_b0");
    idle_to(16);
    issue(RD, 2'd0, 1'b0, 1'b0, "rd_before_trcd");
    issue(RD, 2'd0, 1'b0, 1'b1, "rd_at_trcd");
    chk("b0_busy_actg", {31'd0, bank_busy[0]}, 32'd1);
    issue(WR, 2'd0, 1'b0, 1'b1, "wr_open");
    chk("b0_open", {31'd0, bank_open[0]}, 32'd1);
    issue(RSV, 2'd1, 1'b0, 1'b0, "reserved_cmd");
    issue(PRE, 2'd3, 1'b0, 1'b1, "pre_idle_noop");
    issue(NOP, 2'd0, 1'b0, 1'b1, "nop_valid");
    chk("b3_idle", {30'd0, bank_busy[3], bank_open[3]}, 32'd0);
    idle_to(40);

    // tRAS / tRP boundaries on bank 1
    do_reset();
    issue(ACT, 2'd1, 1'b0, 1'b1, "act_b1");
    idle_to(38);
    issue(PRE, 2'd1, 1'b0, 1'b0, "pre_before_tras");
    issue(PRE, 2'd1, 1'b0, 1'b1, "pre_at_tras");
    idle();
    chk("b1_prechg", {30'd0, bank_busy[1], bank_open[1]}, 32'd2);
    idle_to(56);
    issue(ACT, 2'd1, 1'b0, 1'b0, "act_during_trp");
    chk("b1_busy_end", {31'd0, bank_busy[1]}, 32'd1);
    issue(ACT, 2'd1, 1'b0, 1'b1, "act_after_trp");
    chk("b1_idle", {31'd0, bank_busy[1]}, 32'd0);

    // Refresh gating
    do_reset();
    issue(ACT, 2'd2, 1'b0, 1'b1, "act_b2");
    idle_to(37);
    issue(REF, 2'd0, 1'b0, 1'b0, "ref_bank_open");
    issue(PREA, 2'd0, 1'b0, 1'b0, "prea_before_tras");
    issue(PREA, 2'd0, 1'b0, 1'b1, "prea_ok");
    idle_to(56);
    issue(REF, 2'd0, 1'b0, 1'b0, "ref_during_trp");
    issue(REF, 2'd0, 1'b0, 1'b1, "ref_ok");
    idle();
    chk("ref_busy_rise", {31'd0, ref_busy}, 32'd1);
    issue(ACT, 2'd0, 1'b0, 1'b0, "act_in_refresh");
    issue(NOP, 2'd0, 1'b0, 1'b1, "nop_in_refresh");
    idle_to(200);
    issue(ACT, 2'd3, 1'b0, 1'b0, "act_mid_refresh");
    idle_to(404);
    issue(ACT, 2'd0, 1'b0, 1'b0, "act_last_trfc");
    chk("ref_busy_last", {31'd0, ref_busy}, 32'd1);
    issue(ACT, 2'd0, 1'b0, 1'b1, "act_after_trfc");
    chk("ref_busy_fall", {31'd0, ref_busy}, 32'd0);

    // Back-to-back reads across four banks, then reset with reads in flight
    do_reset();
    for (int b = 0; b < 4; b++) issue(ACT, 2'(b), 1'b0, 1'b1, "act_all");
    idle_to(20);
    for (int i = 0; i < 8; i++) issue(RD, 2'(i % 4), 1'b0, 1'b1, "rd_pipe");
    idle_to(48);
    issue(RD, 2'd0, 1'b0, 1'b1, "rd_inflight0");
    issue(RD, 2'd1, 1'b0, 1'b1, "rd_inflight1");
    idle_to(55);
    do_reset();
    issue(ACT, 2'd0, 1'b0, 1'b1, "act_after_rst");
    idle_to(30);

    // Reset mid-refresh
    do_reset();
    issue(REF, 2'd0, 1'b0, 1'b1, "ref_start");
    idle_to(100);
    chk("ref_busy_mid", {31'd0, ref_busy}, 32'd1);
    do_reset();
    issue(ACT, 2'd1, 1'b0, 1'b1, "act_after_ref_rst");

    // Auto-precharge
    do_reset();
    issue(ACT, 2'd0, 1'b0, 1'b1, "act_ap");
    idle_to(17);
`ifdef DRAM_BANK_TIMING_AP_EN
    issue(RD, 2'd0, 1'b1, 1'b1, "rd_ap");
    issue(RD, 2'd0, 1'b0, 1'b0, "rd_after_ap");
    issue(WR, 2'd0, 1'b0, 1'b0, "wr_after_ap");
    idle_to(40);
    chk("ap_open_38", {31'd0, bank_open[0]}, 32'd1);
    idle();
    chk("ap_prechg_39", {30'd0, bank_busy[0], bank_open[0]}, 32'd2);
    idle_to(57);
    chk("ap_busy_55", {31'd0, bank_busy[0]}, 32'd1);
    idle();
    chk("ap_idle_56", {30'd0, bank_busy[0], bank_open[0]}, 32'd0);
`else
    issue(RD, 2'd0, 1'b1, 1'b0, "rd_ap_disabled");
    issue(RD, 2'd0, 1'b0, 1'b1, "rd_no_ap");
    idle_to(41);
    chk("no_ap_open", {31'd0, bank_open[0]}, 32'd1);
`endif
    idle_to(80);

    @(negedge clk);
    @(negedge clk);
    chk("rd_drain", rdq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
